// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int INSTR_BYTES      = 4;
  localparam int IF_XLEN_DEFAULT  = 32;

  // Fetch sequencer states: issue a request, wait for its response,
  // or swallow the response of a request made stale by a redirect.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  // Default-width prefetch entry; the top declares a XLEN-sized twin.
  typedef struct packed {
    logic [IF_XLEN_DEFAULT-1:0] pc;
    logic [31:0]                instr;
  } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous first-word-fall-through FIFO with flush and occupancy count.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_valid,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Next-state: flush wins; otherwise push/pop move pointers and count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = i_push && (count_q != CW'(DEPTH));
    do_pop   = i_pop && (count_q != '0);
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = i_wdata;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign o_rdata = mem_q[rd_ptr_q];
  assign o_valid = (count_q != '0);
  assign o_count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC sequencing, one-outstanding memory request,
// redirect flush, and a prefetch FIFO feeding decode.
// Decode handshake: an entry moves when o_valid && i_ready at a rising edge;
// o_valid never depends on i_ready.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int               XLEN       = 32,
  parameter logic [XLEN-1:0]  RESET_PC   = '0,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_PCSrc,
  input  logic [XLEN-1:0]  i_inAddr,
  output logic             o_mem_req,
  output logic [XLEN-1:0]  o_mem_instrAddr,
  input  logic             i_mem_gnt,
  input  logic             i_mem_rvalid,
  input  logic [31:0]      i_mem_instr,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_instruction,
  output logic [XLEN-1:0]  o_outAddr,
  output fetch_state_t     o_dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] ADDR_MASK = ~XLEN'(INSTR_BYTES - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] issued_pc_q, issued_pc_d;
  logic            req_raw;
  logic            push, flush, pop;
  logic            fifo_valid;
  logic [CW-1:0]   fifo_count;
  entry_t          push_entry, head_entry;

  // Sequencer next-state and request generation; a redirect overrides all.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    req_raw     = 1'b0;
    push        = 1'b0;
    flush       = 1'b0;
    case (state_q)
      S_REQ: begin
        req_raw = (fifo_count < CW'(FIFO_DEPTH));
        if (req_raw && i_mem_gnt) begin
          state_d     = S_WAIT;
          issued_pc_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + XLEN'(INSTR_BYTES);
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          push    = 1'b1;
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (i_mem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (i_PCSrc) begin
      flush      = 1'b1;
      push       = 1'b0;
      fetch_pc_d = i_inAddr & ADDR_MASK;
      case (state_q)
        S_REQ:   state_d = (req_raw && i_mem_gnt) ? S_DROP : S_REQ;
        S_WAIT:  state_d = i_mem_rvalid ? S_REQ : S_DROP;
        S_DROP:  state_d = i_mem_rvalid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Sequencer registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  assign push_entry = '{pc: issued_pc_q, instr: i_mem_instr};
  assign pop        = o_valid && i_ready;

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_flush   (flush),
    .i_push    (push),
    .i_wdata   (push_entry),
    .i_pop     (pop),
    .o_rdata   (head_entry),
    .o_valid   (fifo_valid),
    .o_count   (fifo_count)
  );

  // Outputs are forced quiet while reset is held low.
  assign o_mem_req       = i_reset_n && req_raw;
  assign o_mem_instrAddr = fetch_pc_q;
  assign o_valid         = i_reset_n && fifo_valid;
  assign o_instruction   = i_reset_n ? head_entry.instr : 32'h0;
  assign o_outAddr       = i_reset_n ? head_entry.pc : '0;
  assign o_dbg_state     = state_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a one-cycle-latency memory responder.
module tb_if_fetch_unit;
  import if_pkg::*;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_PCSrc;
  logic [31:0] i_inAddr;
  logic        o_mem_req;
  logic [31:0] o_mem_instrAddr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_instr;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instruction;
  logic [31:0] o_outAddr;
  fetch_state_t o_dbg_state;

  logic        d2_req, d2_valid;
  logic [31:0] d2_addr, d2_instr, d2_out;
  fetch_state_t d2_state;

  int tests = 0;
  int fails = 0;

  // Responder state and recorded traffic.
  bit          gnt_en, rvalid_en, pend;
  logic [31:0] pend_addr;
  logic [31:0] got_pc_q[$];
  logic [31:0] got_in_q[$];
  logic [31:0] issue_q[$];
  logic [31:0] exp_q[$];

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_PCSrc(i_PCSrc), .i_inAddr(i_inAddr),
    .o_mem_req(o_mem_req), .o_mem_instrAddr(o_mem_instrAddr),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_instr(i_mem_instr),
    .o_valid(o_valid), .i_ready(i_ready), .o_instruction(o_instruction),
    .o_outAddr(o_outAddr), .o_dbg_state(o_dbg_state)
  );

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h8000_0000), .FIFO_DEPTH(4)) dut2 (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_PCSrc(i_PCSrc), .i_inAddr(i_inAddr),
    .o_mem_req(d2_req), .o_mem_instrAddr(d2_addr),
    .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_instr(i_mem_instr),
    .o_valid(d2_valid), .i_ready(i_ready), .o_instruction(d2_instr),
    .o_outAddr(d2_out), .o_dbg_state(d2_state)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic drive_mem();
    i_mem_gnt    = gnt_en;
    i_mem_rvalid = pend && rvalid_en;
    i_mem_instr  = (pend && rvalid_en) ? mem_word(pend_addr) : 32'h0;
  endtask

  // One clock: record issue/pop in the current cycle, advance, re-drive.
  task automatic tick();
    logic        issue;
    logic [31:0] a;
    #1;
    issue = o_mem_req && i_mem_gnt;
    a     = o_mem_instrAddr;
    if (o_valid && i_ready) begin
      got_pc_q.push_back(o_outAddr);
      got_in_q.push_back(o_instruction);
    end
    if (issue) issue_q.push_back(a);
    @(posedge i_clk);
    if (i_mem_rvalid) pend = 1'b0;
    if (issue) begin
      pend      = 1'b1;
      pend_addr = a;
    end
    @(negedge i_clk);
    drive_mem();
    #1;
  endtask

  task automatic clear_q();
    got_pc_q.delete();
    got_in_q.delete();
    issue_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    i_reset_n = 1'b0;
    i_PCSrc   = 1'b0;
    pend      = 1'b0;
    gnt_en    = 1'b1;
    rvalid_en = 1'b1;
    drive_mem();
    tick();
    tick();
    i_reset_n = 1'b1;
    drive_mem();
    #1;
    clear_q();
  endtask

  task automatic test_reset();
    i_reset_n = 1'b0;
    i_ready   = 1'b1;
    pend      = 1'b0;
    gnt_en    = 1'b1;
    rvalid_en = 1'b1;
    drive_mem();
    tick();
    tick();
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %0b want 0", o_mem_req); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %0b want 0", o_valid); end
    tests++; if (o_instruction !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h want 0", o_instruction); end
    tests++; if (o_outAddr !== 32'h0) begin fails++; $display("FAIL rst_outaddr: got %h want 0", o_outAddr); end
    i_reset_n = 1'b1;
    #1;
    tests++; if (o_mem_req !== 1'b1) begin fails++; $display("FAIL first_req: got %0b want 1", o_mem_req); end
    tests++; if (o_mem_instrAddr !== 32'h0) begin fails++; $display("FAIL first_addr: got %h want 0", o_mem_instrAddr); end
    tests++; if (o_dbg_state !== S_REQ) begin fails++; $display("FAIL first_state: got %0d want %0d", o_dbg_state, S_REQ); end
    tests++; if (d2_req !== 1'b1) begin fails++; $display("FAIL rv_req: got %0b want 1", d2_req); end
    tests++; if (d2_addr !== 32'h8000_0000) begin fails++; $display("FAIL rv_addr: got %h want 80000000", d2_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    i_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    tests++; if (issue_q.size() != 6) begin fails++; $display("FAIL seq_issues: got %0d want 6", issue_q.size()); end
    tests++; if (got_pc_q.size() != 5) begin fails++; $display("FAIL seq_pops: got %0d want 5", got_pc_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (issue_q.size() > i) begin
        tests++;
        if (issue_q[i] !== exp_q[i]) begin fails++; $display("FAIL seq_addr[%0d]: got %h want %h", i, issue_q[i], exp_q[i]); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      if (got_pc_q.size() > i) begin
        tests++;
        if (got_pc_q[i] !== exp_q[i]) begin fails++; $display("FAIL seq_pc[%0d]: got %h want %h", i, got_pc_q[i], exp_q[i]); end
        tests++;
        if (got_in_q[i] !== mem_word(exp_q[i])) begin fails++; $display("FAIL seq_instr[%0d]: got %h want %h", i, got_in_q[i], mem_word(exp_q[i])); end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    tests++; if (issue_q.size() != 4) begin fails++; $display("FAIL bp_issues: got %0d want 4", issue_q.size()); end
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL bp_req: got %0b want 0", o_mem_req); end
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL bp_valid: got %0b want 1", o_valid); end
    tests++; if (o_outAddr !== 32'h0) begin fails++; $display("FAIL bp_head: got %h want 0", o_outAddr); end
    clear_q();
    i_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'(i * 4));
    tests++; if (got_pc_q.size() < 5) begin fails++; $display("FAIL bp_drain_cnt: got %0d want >=5", got_pc_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (got_pc_q.size() > i) begin
        tests++;
        if (got_pc_q[i] !== exp_q[i]) begin fails++; $display("FAIL bp_drain[%0d]: got %h want %h", i, got_pc_q[i], exp_q[i]); end
      end
    end
    tests++;
    if (issue_q.size() == 0 || issue_q[0] !== 32'h10) begin
      fails++; $display("FAIL bp_resume: got %h want 00000010", (issue_q.size() == 0) ? 32'hx : issue_q[0]);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    i_ready = 1'b0;
    tick();
    tick();
    rvalid_en = 1'b0;
    tick();
    tests++; if (o_dbg_state !== S_WAIT) begin fails++; $display("FAIL rw_pre_state: got %0d want %0d", o_dbg_state, S_WAIT); end
    tests++; if (o_valid !== 1'b1) begin fails++; $display("FAIL rw_pre_valid: got %0b want 1", o_valid); end
    i_PCSrc  = 1'b1;
    i_inAddr = 32'h100;
    clear_q();
    tick();
    i_PCSrc = 1'b0;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rw_flush: got %0b want 0", o_valid); end
    tests++; if (o_dbg_state !== S_DROP) begin fails++; $display("FAIL rw_state: got %0d want %0d", o_dbg_state, S_DROP); end
    rvalid_en = 1'b1;
    i_ready   = 1'b1;
    drive_mem();
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rw_discard: got %0b want 0", o_valid); end
    tests++; if (o_mem_instrAddr !== 32'h100 || o_mem_req !== 1'b1) begin fails++; $display("FAIL rw_target: got %h/%0b want 00000100/1", o_mem_instrAddr, o_mem_req); end
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (got_pc_q.size() == 0 || got_pc_q[0] !== 32'h100) begin
      fails++; $display("FAIL rw_first_pc: got %h want 00000100", (got_pc_q.size() == 0) ? 32'hx : got_pc_q[0]);
    end
  endtask

  task automatic test_redirect_gnt();
    do_reset();
    i_ready  = 1'b1;
    i_PCSrc  = 1'b1;
    i_inAddr = 32'h203;
    tick();
    i_PCSrc = 1'b0;
    tests++; if (o_dbg_state !== S_DROP) begin fails++; $display("FAIL rg_state: got %0d want %0d", o_dbg_state, S_DROP); end
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rg_stale: got %0b want 0", o_valid); end
    tests++; if (o_mem_instrAddr !== 32'h200 || o_mem_req !== 1'b1) begin fails++; $display("FAIL rg_target: got %h/%0b want 00000200/1", o_mem_instrAddr, o_mem_req); end
    clear_q();
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (got_pc_q.size() == 0 || got_pc_q[0] !== 32'h200) begin
      fails++; $display("FAIL rg_first_pc: got %h want 00000200", (got_pc_q.size() == 0) ? 32'hx : got_pc_q[0]);
    end
  endtask

  task automatic test_redirect_rvalid();
    do_reset();
    i_ready = 1'b1;
    tick();
    tests++; if (i_mem_rvalid !== 1'b1 || o_dbg_state !== S_WAIT) begin fails++; $display("FAIL rr_setup: got %0b/%0d want 1/%0d", i_mem_rvalid, o_dbg_state, S_WAIT); end
    i_PCSrc  = 1'b1;
    i_inAddr = 32'h203;
    tick();
    i_PCSrc = 1'b0;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rr_stale: got %0b want 0", o_valid); end
    tests++; if (o_mem_instrAddr !== 32'h200 || o_mem_req !== 1'b1) begin fails++; $display("FAIL rr_target: got %h/%0b want 00000200/1", o_mem_instrAddr, o_mem_req); end
    clear_q();
    for (int i = 0; i < 4; i++) tick();
    tests++;
    if (got_pc_q.size() == 0 || got_pc_q[0] !== 32'h200) begin
      fails++; $display("FAIL rr_first_pc: got %h want 00000200", (got_pc_q.size() == 0) ? 32'hx : got_pc_q[0]);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    i_ready = 1'b0;
    gnt_en  = 1'b0;
    drive_mem();
    i_PCSrc  = 1'b1;
    i_inAddr = 32'hFFFF_FFFC;
    tick();
    i_PCSrc = 1'b0;
    tests++; if (o_mem_instrAddr !== 32'hFFFF_FFFC || o_mem_req !== 1'b1) begin fails++; $display("FAIL wrap_top: got %h/%0b want fffffffc/1", o_mem_instrAddr, o_mem_req); end
    gnt_en = 1'b1;
    drive_mem();
    tick();
    tick();
    tests++; if (o_mem_instrAddr !== 32'h0) begin fails++; $display("FAIL wrap_next: got %h want 00000000", o_mem_instrAddr); end
    tests++; if (o_outAddr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_pc: got %h want fffffffc", o_outAddr); end
    tests++; if (o_instruction !== mem_word(32'hFFFF_FFFC)) begin fails++; $display("FAIL wrap_instr: got %h want %h", o_instruction, mem_word(32'hFFFF_FFFC)); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rvalid_en = 1'b0;
    tick();
    tests++; if (o_dbg_state !== S_WAIT) begin fails++; $display("FAIL mr_state: got %0d want %0d", o_dbg_state, S_WAIT); end
    i_reset_n = 1'b0;
    #1;
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL mr_valid: got %0b want 0", o_valid); end
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL mr_req: got %0b want 0", o_mem_req); end
    tick();
    i_reset_n = 1'b1;
    rvalid_en = 1'b1;
    drive_mem();
    clear_q();
    #1;
    tests++; if (o_mem_req !== 1'b1 || o_mem_instrAddr !== 32'h0) begin fails++; $display("FAIL mr_first: got %0b/%h want 1/00000000", o_mem_req, o_mem_instrAddr); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL mr_empty: got %0b want 0", o_valid); end
    tick();
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL mr_late: got %0b want 0", o_valid); end
    tick();
    tests++; if (o_valid !== 1'b1 || o_outAddr !== 32'h0) begin fails++; $display("FAIL mr_fresh: got %0b/%h want 1/00000000", o_valid, o_outAddr); end
    tests++; if (o_instruction !== mem_word(32'h0)) begin fails++; $display("FAIL mr_instr: got %h want %h", o_instruction, mem_word(32'h0)); end
  endtask

  initial begin
    i_reset_n    = 1'b0;
    i_PCSrc      = 1'b0;
    i_inAddr     = 32'h0;
    i_mem_gnt    = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_instr  = 32'h0;
    i_ready      = 1'b1;
    gnt_en       = 1'b1;
    rvalid_en    = 1'b1;
    pend         = 1'b0;
    pend_addr    = 32'h0;
    @(negedge i_clk);
    #1;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_gnt();
    test_redirect_rvalid();
    test_wrap();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
